// File: rtl/csr_trap_ctrl_if.sv
// CSR access, pipeline trap control and interrupt request bundle for csr_trap_ctrl.
// The master side is the pipeline, and the slave side is the trap controller.
interface csr_trap_ctrl_if #(
  parameter int unsigned NUM_LOCAL_IRQ = 4
);
  localparam int unsigned LW = (NUM_LOCAL_IRQ == 0) ? 1 : NUM_LOCAL_IRQ;

  logic [11:0]   csr_raddr;
  logic [11:0]   csr_waddr;
  logic          csr_wen;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          write_pc;
  logic [31:0]   pc_id;
  logic [31:0]   new_mepc;
  logic          syscall;
  logic [1:0]    sys_fn;
  logic          instr_retired;
  logic          irq_ext;
  logic          irq_soft;
  logic          irq_timer;
  logic [LW-1:0] irq_local;
  logic          flush_pipeline;
  logic          trap_in_id;
  logic          int_taken;
  logic [31:0]   trap_vector;

  modport master (
    output csr_raddr, csr_waddr, csr_wen, csr_wdata,
    output write_pc, pc_id, new_mepc, syscall, sys_fn, instr_retired,
    output irq_ext, irq_soft, irq_timer, irq_local,
    input  csr_rdata, flush_pipeline, trap_in_id, int_taken, trap_vector
  );

  modport slave (
    input  csr_raddr, csr_waddr, csr_wen, csr_wdata,
    input  write_pc, pc_id, new_mepc, syscall, sys_fn, instr_retired,
    input  irq_ext, irq_soft, irq_timer, irq_local,
    output csr_rdata, flush_pipeline, trap_in_id, int_taken, trap_vector
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file with ecall/ebreak/mret handling and interrupt entry.
// An interrupt entry drains the pipeline for FLUSH_COUNT advances before it commits.
module csr_trap_ctrl #(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter logic [3:0]  FLUSH_COUNT   = 4'd13,
  parameter int unsigned COUNTERS_EN   = 1
) (
  input logic            i_clk,
  input logic            i_rst,
  csr_trap_ctrl_if.slave bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;

  localparam logic [31:0] MISA_VAL   = 32'h4000_0100;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] LOCAL_MASK = (NUM_LOCAL_IRQ == 0) ? 32'h0 :
                                       (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);
  localparam logic [31:0] IRQ_MASK   = LOCAL_MASK | 32'h0000_0888;
  localparam logic        CNT_ON     = (COUNTERS_EN != 0);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_count;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic [31:0] r_csr_rdata;
  logic [31:0] r_trap_vector;
  logic        r_flush;
  logic        r_trap_in_id;
  logic        r_int_taken;

  logic [31:0] w_mip;
  logic [31:0] w_pend;
  logic        w_irq_hit;
  logic [4:0]  w_irq_id;
  logic [31:0] w_mtvec_base;
  logic [31:0] w_int_vec;
  logic [31:0] w_rval;
  logic [31:0] w_wval;
  logic        w_wr_ok;
  logic        w_we;
  logic        w_eval;
  logic        w_exc;
  logic        w_mret;
  logic        w_int;
  logic        w_commit;
  logic [31:0] w_mret_vec;

  always_comb begin
    w_mip     = '0;
    w_mip[3]  = bus.irq_soft;
    w_mip[7]  = bus.irq_timer;
    w_mip[11] = bus.irq_ext;
    for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
      w_mip[16+i] = bus.irq_local[i];
    end
  end

  assign w_pend = w_mip & r_mie;

  // Fixed priority: external, software, timer, then local lines lowest index first.
  always_comb begin
    w_irq_hit = 1'b0;
    w_irq_id  = '0;
    if (w_pend[11]) begin
      w_irq_hit = 1'b1;
      w_irq_id  = 5'd11;
    end else if (w_pend[3]) begin
      w_irq_hit = 1'b1;
      w_irq_id  = 5'd3;
    end else if (w_pend[7]) begin
      w_irq_hit = 1'b1;
      w_irq_id  = 5'd7;
    end else begin
      for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
        if (w_pend[16+i] && !w_irq_hit) begin
          w_irq_hit = 1'b1;
          w_irq_id  = 5'(16 + i);
        end
      end
    end
  end

  assign w_mtvec_base = r_mtvec & MEPC_MASK;
  assign w_int_vec    = r_mtvec[0] ? (w_mtvec_base + {25'b0, w_irq_id, 2'b00}) : w_mtvec_base;

  always_comb begin
    w_wval  = bus.csr_wdata;
    w_wr_ok = 1'b0;
    case (bus.csr_waddr)
      A_MSTATUS: begin
        w_wval  = bus.csr_wdata & 32'h0000_0088;
        w_wr_ok = 1'b1;
      end
      A_MIE: begin
        w_wval  = bus.csr_wdata & IRQ_MASK;
        w_wr_ok = 1'b1;
      end
      A_MTVEC: begin
        w_wval  = (bus.csr_wdata & MEPC_MASK) | {31'b0, (bus.csr_wdata[1:0] == 2'b01)};
        w_wr_ok = 1'b1;
      end
      A_MEPC: begin
        w_wval  = bus.csr_wdata & MEPC_MASK;
        w_wr_ok = 1'b1;
      end
      A_MSCRATCH, A_MCAUSE, A_MTVAL: w_wr_ok = 1'b1;
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRH: w_wr_ok = CNT_ON;
      default: w_wr_ok = 1'b0;
    endcase
  end

  assign w_we = bus.csr_wen && w_wr_ok;

  always_comb begin
    w_rval = '0;
    case (bus.csr_raddr)
      A_MSTATUS:  w_rval = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      A_MISA:     w_rval = MISA_VAL;
      A_MIE:      w_rval = r_mie;
      A_MTVEC:    w_rval = r_mtvec;
      A_MSCRATCH: w_rval = r_mscratch;
      A_MEPC:     w_rval = r_mepc;
      A_MCAUSE:   w_rval = r_mcause;
      A_MTVAL:    w_rval = r_mtval;
      A_MIP:      w_rval = w_mip;
      A_MCYCLE:   w_rval = CNT_ON ? r_mcycle[31:0]   : '0;
      A_MCYCLEH:  w_rval = CNT_ON ? r_mcycle[63:32]  : '0;
      A_MINSTRET: w_rval = CNT_ON ? r_minstret[31:0] : '0;
      A_MINSTRH:  w_rval = CNT_ON ? r_minstret[63:32] : '0;
      default:    w_rval = '0;
    endcase
  end

  assign w_eval     = (r_state == S_IDLE) && bus.write_pc;
  assign w_exc      = w_eval && bus.syscall && (bus.sys_fn == 2'd0 || bus.sys_fn == 2'd1);
  assign w_mret     = w_eval && bus.syscall && (bus.sys_fn == 2'd2);
  assign w_int      = w_eval && !w_exc && !w_mret && r_mstatus_mie && w_irq_hit;
  assign w_commit   = (r_state == S_FLUSH) && (r_count == FLUSH_COUNT);
  assign w_mret_vec = (bus.csr_wen && bus.csr_waddr == A_MEPC) ? (bus.csr_wdata & MEPC_MASK) : r_mepc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
      r_csr_rdata    <= '0;
      r_trap_vector  <= '0;
      r_flush        <= 1'b0;
      r_trap_in_id   <= 1'b0;
      r_int_taken    <= 1'b0;
    end else begin
      r_csr_rdata <= (w_we && bus.csr_waddr == bus.csr_raddr) ? w_wval : w_rval;

      if (w_we) begin
        case (bus.csr_waddr)
          A_MSTATUS: begin
            r_mstatus_mie  <= w_wval[3];
            r_mstatus_mpie <= w_wval[7];
          end
          A_MIE:      r_mie      <= w_wval;
          A_MTVEC:    r_mtvec    <= w_wval;
          A_MSCRATCH: r_mscratch <= w_wval;
          A_MEPC:     r_mepc     <= w_wval;
          A_MCAUSE:   r_mcause   <= w_wval;
          A_MTVAL:    r_mtval    <= w_wval;
          default: ;
        endcase
      end

      if (CNT_ON) begin
        if (w_we && bus.csr_waddr == A_MCYCLE)        r_mcycle[31:0]  <= w_wval;
        else if (w_we && bus.csr_waddr == A_MCYCLEH)  r_mcycle[63:32] <= w_wval;
        else                                          r_mcycle        <= r_mcycle + 64'd1;

        if (w_we && bus.csr_waddr == A_MINSTRET)      r_minstret[31:0]  <= w_wval;
        else if (w_we && bus.csr_waddr == A_MINSTRH)  r_minstret[63:32] <= w_wval;
        else if (bus.instr_retired)                   r_minstret        <= r_minstret + 64'd1;
      end

      // Trap updates come after the CSR write so they override it in the same cycle.
      r_trap_in_id <= w_exc || w_mret;
      r_int_taken  <= w_commit;

      if (w_exc) begin
        r_mepc         <= bus.pc_id & MEPC_MASK;
        r_mcause       <= (bus.sys_fn == 2'd0) ? 32'd11 : 32'd3;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_trap_vector  <= w_mtvec_base;
      end else if (w_mret) begin
        r_trap_vector  <= w_mret_vec;
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_int) begin
        r_mcause       <= {1'b1, 26'b0, w_irq_id};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_trap_vector  <= w_int_vec;
        r_state        <= S_FLUSH;
        r_count        <= '0;
        r_flush        <= 1'b1;
      end

      if (r_state == S_FLUSH) begin
        if (w_commit) begin
          r_mepc  <= bus.new_mepc & MEPC_MASK;
          r_flush <= 1'b0;
          r_state <= S_IDLE;
        end else if (bus.write_pc) begin
          r_count <= r_count + 4'd1;
        end
      end
    end
  end

  assign bus.csr_rdata      = r_csr_rdata;
  assign bus.trap_vector    = r_trap_vector;
  assign bus.flush_pipeline = r_flush;
  assign bus.trap_in_id     = r_trap_in_id;
  assign bus.int_taken      = r_int_taken;

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have parameter NUM_LOCAL_IRQ, default 4, range 0..16: number of platform local interrupts, mapped to mip/mie bits 16+i.
REQ-002 SHALL have parameter FLUSH_COUNT, default 4'd13: number of write_pc cycles to drain before an interrupt commits.
REQ-003 SHALL have parameter COUNTERS_EN, default 1: when 0, mcycle/minstret read 0 and never count.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 csr_raddr  in  12  CSR read address.
REQ-007 csr_waddr  in  12  CSR write address.
REQ-008 csr_wen  in  1  CSR write strobe.
REQ-009 csr_wdata  in  32  CSR write data.
REQ-010 csr_rdata  out  32  registered read data.
REQ-011 write_pc  in  1  pipeline advance (not stalled).
REQ-012 pc_id  in  32  PC of the instruction in ID.
REQ-013 new_mepc  in  32  resume PC at interrupt commit.
REQ-014 syscall  in  1  system instruction in ID.
REQ-015 sys_fn  in  2  0=ecall, 1=ebreak, 2=mret, 3=none.
REQ-016 instr_retired  in  1  one instruction retired this cycle.
REQ-017 irq_ext, irq_soft, irq_timer  in  1 each  level interrupt requests.
REQ-018 irq_local  in  NUM_LOCAL_IRQ (min 1)  level local interrupts.
REQ-019 flush_pipeline, trap_in_id, int_taken  out  1 each  trap control.
REQ-020 trap_vector  out  32  redirect target.

Function
REQ-021 SHALL implement mstatus 0x300 (bits 3 MIE, 7 MPIE writable, others 0), misa 0x301 read-only 0x40000100, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344 read-only, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82; other addresses read 0, writes ignored.
REQ-022 mip SHALL be {irq_local at 16+i, irq_ext at 11, irq_timer at 7, irq_soft at 3}; mie writable only at those bits.
REQ-023 mtvec SHALL keep mode bits 1:0 as 00 (direct) or 01 (vectored); written 1x stores 00.
REQ-024 csr_rdata SHALL update every cycle with value of csr_raddr; if csr_wen and csr_waddr==csr_raddr, SHALL return masked csr_wdata.
REQ-025 Counters: mcycle +1 every cycle, minstret +1 when instr_retired, 64-bit wrap; a CSR write to a half SHALL win over that cycle's increment of that counter.
REQ-026 FSM states IDLE, FLUSH; evaluation in IDLE only when write_pc=1; syscalls outrank interrupts.
REQ-027 ecall/ebreak: mepc<=pc_id, mcause 11/3, MPIE<=MIE, MIE<=0, trap_vector<=mtvec base, trap_in_id=1 next cycle.
REQ-028 mret: trap_vector<=mepc (csr_wdata if same-cycle mepc write), MIE<=MPIE, MPIE<=1, trap_in_id=1 next cycle.
REQ-029 Interrupt when MIE=1 and (mip&mie)!=0: priority ext > soft > timer > local lowest index; mcause={1,id}; MPIE<=MIE, MIE<=0; enter FLUSH, count<=0, flush_pipeline=1.
REQ-030 Vectored mode: interrupt trap_vector = base + 4*id; exceptions always use base.
REQ-031 FLUSH: count +1 per write_pc; at count==FLUSH_COUNT: mepc<=new_mepc, int_taken=1 for one cycle, flush_pipeline=0, go IDLE; syscalls and new interrupts ignored in FLUSH.
REQ-032 trap_in_id SHALL be a one-cycle pulse; cleared on any IDLE write_pc cycle without trap.
REQ-033 Hardware trap updates SHALL win over same-cycle CSR writes to mstatus/mcause/mepc.

Reset
REQ-034 On reset: all CSRs 0 except misa; counters 0; state IDLE; csr_rdata, trap_vector 0; flush_pipeline, trap_in_id, int_taken 0; reset mid-FLUSH aborts with no mepc update.

Verification
REQ-035 Write mtvec=0x101, mie=0x800, mstatus=0x8, raise irq_ext, 13 write_pc -> mcause 0x8000000B, trap_vector 0x12C, int_taken one pulse, mepc=new_mepc.
REQ-036 irq_soft+irq_timer+irq_local[0] together, all enabled -> mcause 0x80000003.
REQ-037 ecall at pc_id 0x80 -> mepc 0x80, mcause 11, MIE 0, trap_in_id pulse; mret -> trap_vector 0x80, MIE 1.
REQ-038 mepc write 0x200 same cycle as mret -> trap_vector 0x200.
REQ-039 Write mcycle=0xFFFFFFFF -> next cycles mcycleh reads 1, mcycle 0.
REQ-040 Reset asserted at flush count 5 -> flush_pipeline 0, mepc 0, no int_taken.
